wvb_trig_gen: RTL and testbench

Trigger generator directly upstream of the waveform buffer. It drives the buffer's trig, trig_src and tot inputs from three sources: an ADC threshold discriminator, an external trigger pin and a software pulse. It arbitrates simultaneous sources, applies a configurable holdoff after each issued trigger, and keeps issued/dropped trigger counters for register readback.

---
 rtl/wvb_trig_pkg.sv | 17 +
 rtl/wvb_ext_trig_sync.sv | 31 +++
 rtl/wvb_trig_gen.sv | 142 ++++++++++++++
 tb/tb_wvb_trig_gen.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wvb_trig_pkg.sv
// Shared definitions for the waveform-buffer trigger generator:
// trigger source codes and counter widths.
package wvb_trig_pkg;

  typedef enum logic [1:0] {
    TRIG_SRC_NONE   = 2'd0,
    TRIG_SRC_THRESH = 2'd1,
    TRIG_SRC_SW     = 2'd2,
    TRIG_SRC_EXT    = 2'd3
  } trig_src_e;

  localparam int TRIG_CNT_BITS = 32;
  localparam int DROP_CNT_BITS = 16;

  localparam logic [DROP_CNT_BITS-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/wvb_ext_trig_sync.sv
// N-stage synchronizer for the asynchronous external trigger level, followed
// by a rising-edge detector producing a one-cycle pulse.
module wvb_ext_trig_sync #(
  parameter int P_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [P_STAGES-1:0] sync_q, sync_d;
  logic                last_q, last_d;

  always_comb begin
    sync_d = {sync_q[P_STAGES-2:0], async_in};
    last_d = sync_q[P_STAGES-1];
    rise   = sync_q[P_STAGES-1] & ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/wvb_trig_gen.sv
// Trigger generator feeding the waveform buffer: arbitrates threshold, external
// and software sources, applies holdoff, counts issued/dropped triggers.
// Optional threshold prescaler enabled by defining WVB_TRIG_GEN_PRESCALE_EN.
module wvb_trig_gen
  import wvb_trig_pkg::*;
#(
  parameter int P_ADC_BITS     = 12,
  parameter int P_HOLDOFF_BITS = 12,
  parameter int P_SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [P_ADC_BITS-1:0]     adc_in,
  input  logic [P_ADC_BITS-1:0]     thresh,
  input  logic                      thresh_trig_en,
  input  logic                      ext_trig_en,
  input  logic                      ext_trig_in,
  input  logic                      sw_trig,
  input  logic [P_HOLDOFF_BITS-1:0] holdoff_conf,
  input  logic                      cnt_clr,
`ifdef WVB_TRIG_GEN_PRESCALE_EN
  input  logic [7:0]                prescale_conf,
`endif
  output logic                      trig,
  output logic [1:0]                trig_src,
  output logic                      tot,
  output logic [TRIG_CNT_BITS-1:0]  trig_cnt,
  output logic [DROP_CNT_BITS-1:0]  drop_cnt,
  output logic                      holdoff_active
);

  logic                      over_q, over_d;
  logic                      trig_q, trig_d;
  trig_src_e                 trig_src_q, trig_src_d;
  logic [P_HOLDOFF_BITS-1:0] hold_cnt_q, hold_cnt_d;
  logic                      holdoff_active_q, holdoff_active_d;
  logic [TRIG_CNT_BITS-1:0]  trig_cnt_q, trig_cnt_d;
  logic [DROP_CNT_BITS-1:0]  drop_cnt_q, drop_cnt_d;
`ifdef WVB_TRIG_GEN_PRESCALE_EN
  logic [7:0]                ps_cnt_q, ps_cnt_d;
`endif

  logic      ext_rise;
  logic      thresh_evt;
  logic      ext_evt;
  logic      any_evt;
  logic      hold_busy;
  logic      issue;
  trig_src_e win_src;

  wvb_ext_trig_sync #(
    .P_STAGES (P_SYNC_STAGES)
  ) u_ext_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ext_trig_in),
    .rise     (ext_rise)
  );

  always_comb begin
    over_d     = (adc_in > thresh);
    thresh_evt = thresh_trig_en & over_d & ~over_q;
    ext_evt    = ext_trig_en & ext_rise;
    any_evt    = ext_evt | sw_trig | thresh_evt;
    hold_busy  = (hold_cnt_q != '0);
    win_src    = ext_evt ? TRIG_SRC_EXT : (sw_trig ? TRIG_SRC_SW : TRIG_SRC_THRESH);
    issue      = any_evt & ~hold_busy;

`ifdef WVB_TRIG_GEN_PRESCALE_EN
    // Skipped threshold triggers behave as if they never happened: no holdoff, no counts.
    ps_cnt_d = ps_cnt_q;
    if (issue && (win_src == TRIG_SRC_THRESH)) begin
      if (ps_cnt_q == prescale_conf) begin
        ps_cnt_d = '0;
      end else begin
        ps_cnt_d = ps_cnt_q + 8'd1;
        issue    = 1'b0;
      end
    end
`endif

    trig_d           = issue;
    trig_src_d       = issue ? win_src : TRIG_SRC_NONE;
    holdoff_active_d = hold_busy;

    hold_cnt_d = hold_cnt_q;
    if (issue) begin
      hold_cnt_d = holdoff_conf;
    end else if (hold_busy) begin
      hold_cnt_d = hold_cnt_q - P_HOLDOFF_BITS'(1);
    end

    trig_cnt_d = issue ? trig_cnt_q + TRIG_CNT_BITS'(1) : trig_cnt_q;

    drop_cnt_d = drop_cnt_q;
    if (any_evt && hold_busy && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_BITS'(1);
    end

    if (cnt_clr) begin
      trig_cnt_d = '0;
      drop_cnt_d = '0;
`ifdef WVB_TRIG_GEN_PRESCALE_EN
      ps_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      over_q           <= 1'b0;
      trig_q           <= 1'b0;
      trig_src_q       <= TRIG_SRC_NONE;
      hold_cnt_q       <= '0;
      holdoff_active_q <= 1'b0;
      trig_cnt_q       <= '0;
      drop_cnt_q       <= '0;
`ifdef WVB_TRIG_GEN_PRESCALE_EN
      ps_cnt_q         <= '0;
`endif
    end else begin
      over_q           <= over_d;
      trig_q           <= trig_d;
      trig_src_q       <= trig_src_d;
      hold_cnt_q       <= hold_cnt_d;
      holdoff_active_q <= holdoff_active_d;
      trig_cnt_q       <= trig_cnt_d;
      drop_cnt_q       <= drop_cnt_d;
`ifdef WVB_TRIG_GEN_PRESCALE_EN
      ps_cnt_q         <= ps_cnt_d;
`endif
    end
  end

  assign trig           = trig_q;
  assign trig_src       = trig_src_q;
  assign tot            = over_q;
  assign trig_cnt       = trig_cnt_q;
  assign drop_cnt       = drop_cnt_q;
  assign holdoff_active = holdoff_active_q;

endmodule

// File: tb/tb_wvb_trig_gen.sv
// Scoreboard testbench for wvb_trig_gen (default build): directed scenarios plus
// randomized traffic checked against a cycle-numbered behavioural model.
module tb_wvb_trig_gen;

   localparam int ADC_BITS  = 12;
   localparam int HOLD_BITS = 12;
   localparam int NSYNC     = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [ADC_BITS-1:0]  adc_in;
   logic [ADC_BITS-1:0]  thresh;
   logic                 thresh_trig_en;
   logic                 ext_trig_en;
   logic                 ext_trig_in;
   logic                 sw_trig;
   logic [HOLD_BITS-1:0] holdoff_conf;
   logic                 cnt_clr;
   logic                 trig;
   logic [1:0]           trig_src;
   logic                 tot;
   logic [31:0]          trig_cnt;
   logic [15:0]          drop_cnt;
   logic                 holdoff_active;

   wvb_trig_gen #(
      .P_ADC_BITS     (ADC_BITS),
      .P_HOLDOFF_BITS (HOLD_BITS),
      .P_SYNC_STAGES  (NSYNC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .adc_in         (adc_in),
      .thresh         (thresh),
      .thresh_trig_en (thresh_trig_en),
      .ext_trig_en    (ext_trig_en),
      .ext_trig_in    (ext_trig_in),
      .sw_trig        (sw_trig),
      .holdoff_conf   (holdoff_conf),
      .cnt_clr        (cnt_clr),
      .trig           (trig),
      .trig_src       (trig_src),
      .tot            (tot),
      .trig_cnt       (trig_cnt),
      .drop_cnt       (drop_cnt),
      .holdoff_active (holdoff_active)
   );

   always #5 clk = ~clk;

   // Cycle number = count of rising edges so far; inputs driven at cycle n are
   // sampled at edge n+1 and their registered response is visible in cycle n+1.
   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic                 rst;
      logic [ADC_BITS-1:0]  adc;
      logic [ADC_BITS-1:0]  thresh;
      logic                 ten;
      logic                 een;
      logic                 ext;
      logic                 sw;
      logic [HOLD_BITS-1:0] hold;
      logic                 clr;
   } stim_t;

   typedef struct packed {
      logic        trig;
      logic [1:0]  src;
      logic        tot;
      logic        hoa;
      logic [31:0] tcnt;
      logic [15:0] dcnt;
   } status_t;

   typedef struct {
      int      cyc;
      status_t st;
   } stat_item_t;

   typedef struct {
      int         cyc;
      logic [1:0] src;
   } trig_item_t;

   stat_item_t stat_q[$];
   trig_item_t trig_q[$];

   // Reference model state: absolute cycle numbers instead of a down-counter.
   bit          m_prev_over = 1'b0;
   bit          m_ext_hist[NSYNC+2];
   logic [31:0] m_tcnt = '0;
   int          m_dcnt = 0;
   int          m_next_ok = 0;

   function automatic stim_t idle();
      stim_t s;
      s.rst    = 1'b0;
      s.adc    = '0;
      s.thresh = 12'd100;
      s.ten    = 1'b1;
      s.een    = 1'b1;
      s.ext    = 1'b0;
      s.sw     = 1'b0;
      s.hold   = '0;
      s.clr    = 1'b0;
      return s;
   endfunction

   // Drive one cycle of inputs and push the model's expected response for the next cycle.
   task automatic applyStimulus(input stim_t s);
      bit         over, thr_evt, ext_evt, busy, any;
      logic [1:0] src;
      status_t    e;
      int         n;
      @(negedge clk);
      n              = cyc;
      rst            = s.rst;
      adc_in         = s.adc;
      thresh         = s.thresh;
      thresh_trig_en = s.ten;
      ext_trig_en    = s.een;
      ext_trig_in    = s.ext;
      sw_trig        = s.sw;
      holdoff_conf   = s.hold;
      cnt_clr        = s.clr;
      e = '0;
      if (s.rst) begin
         m_prev_over = 1'b0;
         foreach (m_ext_hist[i]) m_ext_hist[i] = 1'b0;
         m_tcnt    = '0;
         m_dcnt    = 0;
         m_next_ok = 0;
      end else begin
         over        = (s.adc > s.thresh);
         thr_evt     = over && !m_prev_over && s.ten;
         m_prev_over = over;
         for (int i = NSYNC + 1; i > 0; i--) m_ext_hist[i] = m_ext_hist[i-1];
         m_ext_hist[0] = s.ext;
         ext_evt = m_ext_hist[NSYNC] && !m_ext_hist[NSYNC+1] && s.een;
         busy    = (n < m_next_ok);
         any     = ext_evt || s.sw || thr_evt;
         if (any && !busy) begin
            src    = ext_evt ? 2'd3 : (s.sw ? 2'd2 : 2'd1);
            e.trig = 1'b1;
            e.src  = src;
            m_tcnt = m_tcnt + 32'd1;
            m_next_ok = n + 1 + int'(s.hold);
            trig_q.push_back('{n + 1, src});
         end else if (any && m_dcnt < 65535) begin
            m_dcnt++;
         end
         if (s.clr) begin
            m_tcnt = '0;
            m_dcnt = 0;
         end
         e.tot = over;
         e.hoa = busy;
      end
      e.tcnt = m_tcnt;
      e.dcnt = 16'(m_dcnt);
      stat_q.push_back('{n + 1, e});
   endtask

   // Compare an observed value against a bench-computed constant.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the per-cycle status and, whenever trig is presented, the trigger scoreboard.
   initial begin
      stat_item_t it;
      trig_item_t ti;
      status_t    act;
      forever begin
         @(negedge clk);
         if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
            it  = stat_q.pop_front();
            act = {trig, trig_src, tot, holdoff_active, trig_cnt, drop_cnt};
            tests++;
            if (act !== it.st) begin
               fails++;
               $display("[TB] FAIL status cyc=%0d got %h expected %h (trig,src,tot,hoa,tcnt,dcnt)",
                        cyc, act, it.st);
            end
         end
         if (trig === 1'b1) begin
            tests++;
            if (trig_q.size() == 0 || trig_q[0].cyc != cyc) begin
               fails++;
               $display("[TB] FAIL unexpected trig cyc=%0d got src=%0d expected no trig", cyc, trig_src);
            end else begin
               ti = trig_q.pop_front();
               if (trig_src !== ti.src) begin
                  fails++;
                  $display("[TB] FAIL trig_src cyc=%0d got %0d expected %0d", cyc, trig_src, ti.src);
               end
            end
         end else if (trig_q.size() > 0 && trig_q[0].cyc <= cyc) begin
            tests++;
            fails++;
            ti = trig_q.pop_front();
            $display("[TB] FAIL missed trig cyc=%0d got trig=%b expected src=%0d", cyc, trig, ti.src);
         end
      end
   end

   initial begin
      #(10_000_000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      stim_t s;
      logic  ext_lvl;
      rst = 1'b1; adc_in = '0; thresh = 12'd100; thresh_trig_en = 1'b1; ext_trig_en = 1'b1;
      ext_trig_in = 1'b0; sw_trig = 1'b0; holdoff_conf = '0; cnt_clr = 1'b0;
      foreach (m_ext_hist[i]) m_ext_hist[i] = 1'b0;

      // Reset state
      s = idle(); s.rst = 1'b1;
      repeat (3) applyStimulus(s);
      s = idle();
      applyStimulus(s);
      checkOutput("reset trig_cnt", trig_cnt, 32'd0);
      checkOutput("reset drop_cnt", {16'd0, drop_cnt}, 32'd0);
      checkOutput("reset tot", {31'd0, tot}, 32'd0);

      // Threshold ramp crossing 100
      for (int a = 90; a <= 110; a++) begin
         s.adc = 12'(a);
         applyStimulus(s);
      end
      repeat (3) applyStimulus(s);
      checkOutput("ramp trig_cnt", trig_cnt, 32'd1);
      checkOutput("ramp tot", {31'd0, tot}, 32'd1);

      // Holdoff of 10 with software triggers at relative cycles 0, 5 and 11
      s = idle(); s.clr = 1'b1;
      applyStimulus(s);
      s.clr  = 1'b0;
      s.hold = 12'd10;
      for (int i = 0; i < 26; i++) begin
         s.sw = (i == 0 || i == 5 || i == 11);
         applyStimulus(s);
      end
      checkOutput("holdoff drop_cnt", {16'd0, drop_cnt}, 32'd1);
      checkOutput("holdoff trig_cnt", trig_cnt, 32'd2);

      // Software and threshold events in the same cycle
      s = idle(); s.clr = 1'b1;
      applyStimulus(s);
      s.clr = 1'b0; s.adc = 12'd200; s.sw = 1'b1;
      applyStimulus(s);
      s.sw = 1'b0;
      repeat (3) applyStimulus(s);
      s.adc = '0;
      applyStimulus(s);
      checkOutput("simult trig_cnt", trig_cnt, 32'd1);
      checkOutput("simult drop_cnt", {16'd0, drop_cnt}, 32'd0);

      // External level held for 20 cycles gives one trigger
      s = idle(); s.clr = 1'b1;
      applyStimulus(s);
      s.clr = 1'b0; s.ext = 1'b1;
      repeat (20) applyStimulus(s);
      s.ext = 1'b0;
      repeat (6) applyStimulus(s);
      checkOutput("ext trig_cnt", trig_cnt, 32'd1);

      // External edge while disabled, then re-enabled with level still high
      s = idle(); s.clr = 1'b1;
      applyStimulus(s);
      s.clr = 1'b0; s.een = 1'b0; s.ext = 1'b1;
      repeat (6) applyStimulus(s);
      s.een = 1'b1;
      repeat (6) applyStimulus(s);
      s.ext = 1'b0;
      repeat (4) applyStimulus(s);
      checkOutput("ext disabled trig_cnt", trig_cnt, 32'd0);

      // Threshold crossing while disabled
      s.ten = 1'b0; s.adc = 12'd200;
      repeat (3) applyStimulus(s);
      s.adc = '0;
      applyStimulus(s);
      s.ten = 1'b1;
      applyStimulus(s);
      checkOutput("thresh disabled trig_cnt", trig_cnt, 32'd0);
      checkOutput("thresh disabled drop_cnt", {16'd0, drop_cnt}, 32'd0);

      // Reset in the middle of a long holdoff
      s = idle(); s.hold = 12'd1000; s.sw = 1'b1;
      applyStimulus(s);
      s.sw = 1'b0;
      repeat (5) applyStimulus(s);
      s.rst = 1'b1;
      applyStimulus(s);
      s.rst = 1'b0;
      applyStimulus(s);
      checkOutput("mid-holdoff reset hoa", {31'd0, holdoff_active}, 32'd0);
      checkOutput("mid-holdoff reset trig_cnt", trig_cnt, 32'd0);
      s.sw = 1'b1;
      applyStimulus(s);
      s.sw = 1'b0;
      repeat (2) applyStimulus(s);
      checkOutput("post-reset trig_cnt", trig_cnt, 32'd1);

      // Counter clear in the same cycle as a trigger
      s = idle(); s.rst = 1'b1;
      applyStimulus(s);
      s.rst = 1'b0; s.sw = 1'b1; s.clr = 1'b1;
      applyStimulus(s);
      s = idle();
      applyStimulus(s);
      checkOutput("clr+trig trig", {31'd0, trig}, 32'd1);
      checkOutput("clr+trig trig_cnt", trig_cnt, 32'd0);

      // Randomized traffic
      ext_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         s.rst    = (($urandom % 400) == 0);
         s.thresh = 12'd2000;
         s.adc    = 12'(1990 + ($urandom % 20));
         s.ten    = (($urandom % 8) != 0);
         s.een    = (($urandom % 8) != 0);
         if (($urandom % 6) == 0) ext_lvl = ~ext_lvl;
         s.ext    = ext_lvl;
         s.sw     = (($urandom % 12) == 0);
         s.hold   = 12'($urandom % 12);
         s.clr    = (($urandom % 150) == 0);
         applyStimulus(s);
      end

      // Drop counter saturation under continuous software triggers
      s = idle(); s.rst = 1'b1;
      applyStimulus(s);
      s = idle(); s.hold = 12'hFFF; s.sw = 1'b1;
      repeat (70000) applyStimulus(s);
      s.sw = 1'b0;
      repeat (2) applyStimulus(s);
      checkOutput("drop_cnt saturation", {16'd0, drop_cnt}, 32'h0000FFFF);

      s = idle(); s.rst = 1'b1;
      repeat (3) applyStimulus(s);
      @(negedge clk);
      #1;
      checkOutput("trig scoreboard drained", trig_q.size(), 32'd0);
      checkOutput("status scoreboard drained", stat_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
